// File: rtl/fetch_exec_ctrl.sv
// fetch_exec_ctrl: fetch/decode/execute sequencer for an 8-bit accumulator ISA.
// Drives the PC strobes and the synchronous RAM port; holds acc, ir and zero.
module fetch_exec_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic [DATA_W-1:0] ram_q,
   output logic              load_pc,
   output logic              incr_pc,
   output logic [ADDR_W-1:0] pc_addr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   output logic [DATA_W-1:0] acc,
   output logic [DATA_W-1:0] ir,
   output logic              zero,
   output logic              halted,
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_OPERAND = 3'd2,
      S_EXEC    = 3'd3,
      S_HALT    = 3'd4
   } state_e;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_LDA  = 4'h2;
   localparam logic [3:0] OP_STA  = 4'h3;
   localparam logic [3:0] OP_ADD  = 4'h4;
   localparam logic [3:0] OP_SUB  = 4'h5;
   localparam logic [3:0] OP_JMP  = 4'h6;
   localparam logic [3:0] OP_JZ   = 4'h7;
   localparam logic [3:0] OP_HALT = 4'hF;

   state_e            state_q;
   logic [DATA_W-1:0] acc_q;
   logic [DATA_W-1:0] ir_q;
   logic              zero_q;

   logic [3:0]        dec_op;
   logic [3:0]        ir_op;
   logic              dec_two;
   logic [DATA_W-1:0] exec_d;

   // Opcode of the byte arriving in DECODE, and of the latched instruction
   assign dec_op  = ram_q[DATA_W-1 -: 4];
   assign ir_op   = ir_q[DATA_W-1 -: 4];
   assign dec_two = (dec_op != OP_NOP) && (dec_op <= OP_JZ);

   // Arithmetic result for the memory-operand instructions in EXEC
   always_comb begin
      exec_d = acc_q;
      case (ir_op)
         OP_LDA:  exec_d = ram_q;
         OP_ADD:  exec_d = acc_q + ram_q;
         OP_SUB:  exec_d = acc_q - ram_q;
         default: exec_d = acc_q;
      endcase
   end

   // Sequencer state plus the architectural registers it owns
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         acc_q   <= '0;
         ir_q    <= '0;
         zero_q  <= 1'b1;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (run) state_q <= S_DECODE;
            end
            S_DECODE: begin
               ir_q <= ram_q;
               if (dec_op == OP_HALT)
                  state_q <= S_HALT;
               else if (dec_two)
                  state_q <= S_OPERAND;
               else
                  state_q <= S_FETCH;
            end
            S_OPERAND: begin
               case (ir_op)
                  OP_LDI: begin
                     acc_q   <= ram_q;
                     zero_q  <= (ram_q == '0);
                     state_q <= S_FETCH;
                  end
                  OP_LDA, OP_ADD, OP_SUB:
                     state_q <= S_EXEC;
                  default:
                     state_q <= S_FETCH;
               endcase
            end
            S_EXEC: begin
               acc_q   <= exec_d;
               zero_q  <= (exec_d == '0);
               state_q <= S_FETCH;
            end
            S_HALT: begin
               state_q <= S_HALT;
            end
            default: begin
               state_q <= S_FETCH;
            end
         endcase
      end
   end

   // PC and RAM strobes decoded from state, ir and the RAM read data
   always_comb begin
      load_pc  = 1'b0;
      incr_pc  = 1'b0;
      pc_addr  = ADDR_W'(ram_q);
      ram_addr = pc_in;
      ram_wren = 1'b0;
      case (state_q)
         S_FETCH: begin
            incr_pc = run;
         end
         S_DECODE: begin
            incr_pc = dec_two;
         end
         S_OPERAND: begin
            case (ir_op)
               OP_STA: begin
                  ram_addr = ADDR_W'(ram_q);
                  ram_wren = 1'b1;
               end
               OP_JMP: load_pc = 1'b1;
               OP_JZ:  load_pc = zero_q;
               OP_LDA, OP_ADD, OP_SUB:
                  ram_addr = ADDR_W'(ram_q);
               default: ;
            endcase
         end
         default: ;
      endcase
      if (reset) begin
         load_pc  = 1'b0;
         incr_pc  = 1'b0;
         ram_wren = 1'b0;
      end
   end

   assign ram_data = acc_q;
   assign acc      = acc_q;
   assign ir       = ir_q;
   assign zero     = zero_q;
   assign halted   = (state_q == S_HALT);
   assign state    = state_q;

endmodule

// File: doc/fetch_exec_ctrl.md
Name: fetch_exec_ctrl

Overview:
Fetch/decode/execute sequencer for the 8-bit program counter and the 256x8 synchronous-read RAM. Drives the PC strobes (load_pc, incr_pc, pc_addr) and the RAM port (ram_addr, ram_data, ram_wren). Holds the accumulator, instruction register and zero flag, executing a 9-opcode accumulator ISA out of RAM. Sits between the pc block, the RAM and the board I/O, which show acc, ir and state on the seven-segment displays.

Parameters:
DATA_W, 8, accumulator/RAM word width
ADDR_W, 8, PC/RAM address width (RAM depth 2**ADDR_W)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; also wired to the pc block reset
run  in  1  level enable; sampled only in FETCH
pc_in  in  ADDR_W  current PC value from the pc block
ram_q  in  DATA_W  RAM read data, valid the cycle after the address edge
load_pc  out  1  pc block: PC <= pc_addr at next edge (priority over incr_pc)
incr_pc  out  1  pc block: PC <= PC+1 at next edge
pc_addr  out  ADDR_W  jump target for load_pc
ram_addr  out  ADDR_W  RAM address, registered by the RAM at next edge
ram_data  out  DATA_W  RAM write data (always = acc)
ram_wren  out  1  RAM write enable
acc  out  DATA_W  accumulator
ir  out  DATA_W  instruction register
zero  out  1  1 when acc == 0
halted  out  1  1 in HALT state
state  out  3  FSM state code, for display

Behaviour:
- ISA (opcode = ir[7:4]; ir[3:0] ignored): 0 NOP; 1 LDI imm; 2 LDA a; 3 STA a; 4 ADD a; 5 SUB a; 6 JMP a; 7 JZ a; F HALT; 8-E execute as NOP. Opcodes 1-7 carry a second byte (imm/a) at PC+1.
- States: FETCH=0, DECODE=1, OPERAND=2, EXEC=3, HALT=4; 5-7 unreachable, recover to FETCH.
- FETCH: ram_addr=pc_in. run=1: incr_pc=1 -> DECODE. run=0: no strobes, stay.
- DECODE: ram_q is the instruction; ir<=ram_q. Opcodes 0, 8-E -> FETCH. F -> HALT. 1-7: ram_addr=pc_in (already incremented), incr_pc=1 -> OPERAND.
- OPERAND (ram_q = operand byte):
  - LDI: acc<=ram_q -> FETCH.
  - STA: ram_addr=ram_q, ram_wren=1 -> FETCH.
  - JMP: load_pc=1, pc_addr=ram_q -> FETCH.
  - JZ: if zero=1, same as JMP; else no strobe -> FETCH.
  - LDA/ADD/SUB: ram_addr=ram_q -> EXEC.
- EXEC (ram_q = mem[a]): LDA acc<=ram_q; ADD acc<=acc+ram_q; SUB acc<=acc-ram_q; all mod 2**DATA_W, carry/borrow discarded -> FETCH.
- zero is registered and updates in the same cycle as every acc write; flag-only ops never change it.
- Cycle counts: NOP/undefined 2; LDI/STA/JMP/JZ 3; LDA/ADD/SUB 4.
- HALT: halted=1, all strobes 0, held until reset; run is ignored.
- ram_addr defaults to pc_in in every state not listed above. Strobes are combinational from state, ir and ram_q. At most one of load_pc/incr_pc is asserted per cycle.
- PC wraps 0xFF->0x00 inside the pc block. An operand fetch at 0xFF reads address 0x00.
- Reset, any cycle including mid-instruction: next state FETCH; acc=0, ir=0, zero=1, halted=0. load_pc, incr_pc and ram_wren are forced 0 during the reset cycle, so no spurious write occurs.
- run deasserted mid-instruction: the current instruction completes, then the FSM idles in FETCH.

Test Plan:
1. Reset, RAM = {10 2A F0}, run=1 -> after 5 cycles: acc=0x2A, zero=0, halted=1, PC=3, state=4.
2. RAM = {10 F0 40 80 F0 ..., [0x80]=20}: ADD wraps -> acc=0x10, zero=0. Then SUB 0x80 with [0x80]=0x10 -> acc=0x00, zero=1.
3. RAM = {10 55 30 90 20 90 F0} -> ram_wren=1 for exactly 1 cycle with ram_addr=0x90, ram_data=0x55; LDA then yields acc=0x55.
4. JZ taken/not taken: acc=0 with JZ 0x40 -> load_pc=1, PC=0x40. acc=1 -> PC advances to next instruction (+2).
5. Assert reset during OPERAND of STA -> ram_wren stays 0, RAM unchanged, state=0, acc=0, PC=0.
6. run=0 after reset -> state stays 0 and PC stays 0 for 10 cycles. Raise run -> fetch begins on the next edge; opcode 0xB0 takes 2 cycles and behaves as NOP.
